// File: rtl/split_load_unit.sv
// Load reader for the synchronous DataRam; word-crossing loads become two back-to-back reads.
// Optional macro SPLIT_LOAD_TRAP_EN: crossing loads fault instead of being split.
module split_load_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [2:0]        LoadType,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [4:0]        RdIn,
  output logic              RamEn,
  output logic [ADDR_W-3:0] RamAddr,
  input  logic [31:0]       RamRd,
  output logic              LoadValid,
  output logic [31:0]       LoadData,
  output logic [4:0]        LoadRd,
  output logic              LoadFault
);

  typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;
  typedef enum logic [2:0] {
    LT_B  = 3'b000,
    LT_H  = 3'b001,
    LT_W  = 3'b010,
    LT_BU = 3'b100,
    LT_HU = 3'b101
  } load_t;

  state_t            state, state_nxt;
  load_t             ltype_q, ltype_in;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;
  logic              cross_q, cross_in;
  logic [ADDR_W-3:0] waddr_q;
  logic              accept;
  logic              second_rd;
  logic [31:0]       data_q;
  logic              valid_q;
  logic [4:0]        lrd_q;
`ifdef SPLIT_LOAD_TRAP_EN
  logic              fault_q;
`else
  logic [31:0]       word0_q;
`endif

  // Little-endian pick: shift the {upper, lower} word pair right by the byte offset.
  function automatic logic [31:0] extract(load_t t, logic [1:0] off, logic [63:0] pair);
    logic [63:0] sh;
    logic [31:0] res;
    sh = pair >> {off, 3'b000};
    case (t)
      LT_B:    res = {{24{sh[7]}}, sh[7:0]};
      LT_BU:   res = {24'h0, sh[7:0]};
      LT_H:    res = {{16{sh[15]}}, sh[15:0]};
      LT_HU:   res = {16'h0, sh[15:0]};
      default: res = sh[31:0];
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RD1;
      RD1: begin
`ifdef SPLIT_LOAD_TRAP_EN
        state_nxt = IDLE;
`else
        if (clear || !cross_q) state_nxt = IDLE;
        else                   state_nxt = RD2;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ReqReady  = (state == IDLE) && !clear;
    accept    = ReqValid && ReqReady;
`ifdef SPLIT_LOAD_TRAP_EN
    second_rd = 1'b0;
`else
    second_rd = (state == RD1) && cross_q && !clear;
`endif
    RamEn     = accept || second_rd;
    if (accept)         RamAddr = Addr[ADDR_W-1:2];
    else if (second_rd) RamAddr = waddr_q + 1'b1;
    else                RamAddr = '0;

    case (LoadType)
      3'b000:  ltype_in = LT_B;
      3'b001:  ltype_in = LT_H;
      3'b100:  ltype_in = LT_BU;
      3'b101:  ltype_in = LT_HU;
      default: ltype_in = LT_W;
    endcase
    case (ltype_in)
      LT_H, LT_HU: cross_in = (Addr[1:0] == 2'd3);
      LT_W:        cross_in = (Addr[1:0] != 2'd0);
      default:     cross_in = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ltype_q <= LT_B;
      off_q   <= '0;
      rd_q    <= '0;
      cross_q <= 1'b0;
      waddr_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      lrd_q   <= '0;
`ifdef SPLIT_LOAD_TRAP_EN
      fault_q <= 1'b0;
`else
      word0_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef SPLIT_LOAD_TRAP_EN
      fault_q <= 1'b0;
`endif
      if (accept) begin
        ltype_q <= ltype_in;
        off_q   <= Addr[1:0];
        rd_q    <= RdIn;
        cross_q <= cross_in;
        waddr_q <= Addr[ADDR_W-1:2];
      end
      // Result registers only change with a pulse, so a clear leaves the previous result intact.
      if (state == RD1 && !clear) begin
        if (!cross_q) begin
          valid_q <= 1'b1;
          data_q  <= extract(ltype_q, off_q, {32'h0, RamRd});
          lrd_q   <= rd_q;
        end else begin
`ifdef SPLIT_LOAD_TRAP_EN
          valid_q <= 1'b1;
          fault_q <= 1'b1;
          data_q  <= '0;
          lrd_q   <= rd_q;
`else
          word0_q <= RamRd;
`endif
        end
      end
`ifndef SPLIT_LOAD_TRAP_EN
      if (state == RD2 && !clear) begin
        valid_q <= 1'b1;
        data_q  <= extract(ltype_q, off_q, {RamRd, word0_q});
        lrd_q   <= rd_q;
      end
`endif
    end
  end

  assign LoadValid = valid_q;
  assign LoadData  = data_q;
  assign LoadRd    = lrd_q;
`ifdef SPLIT_LOAD_TRAP_EN
  assign LoadFault = fault_q;
`else
  assign LoadFault = 1'b0;
`endif

endmodule

// File: tb/tb_split_load_unit.sv
// Scoreboard bench for split_load_unit: directed loads push expectations, a monitor checks each LoadValid.
module tb_split_load_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [2:0]  LoadType = 3'b000;
  logic [31:0] Addr = '0;
  logic [4:0]  RdIn = '0;
  logic        RamEn;
  logic [29:0] RamAddr;
  logic [31:0] RamRd;
  logic [31:0] ram_q = '0;
  logic        LoadValid;
  logic [31:0] LoadData;
  logic [4:0]  LoadRd;
  logic        LoadFault;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned cyc = 0;

  split_load_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .LoadType(LoadType),
    .Addr(Addr), .RdIn(RdIn), .RamEn(RamEn), .RamAddr(RamAddr),
    .RamRd(RamRd), .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadRd(LoadRd), .LoadFault(LoadFault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] mem(logic [29:0] a);
    case (a)
      30'h40:       return 32'h44332211;
      30'h41:       return 32'h88776655;
      30'h3FFFFFFF: return 32'hDDCCBBAA;
      30'h0:        return 32'h11223344;
      default:      return 32'h0;
    endcase
  endfunction

  always @(posedge clk) if (RamEn === 1'b1) ram_q <= mem(RamAddr);
  assign RamRd = ram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (LoadValid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected LoadValid", 32'(LoadData), 32'hFFFF_FFFF);
        if (LoadData === 32'hFFFF_FFFF) begin
          mismatched++;
          $display("FAIL unexpected LoadValid: got pulse expected none");
        end
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("LoadData", LoadData, e.data);
        chk("LoadRd", 32'(LoadRd), 32'(e.rd));
        chk("LoadFault", 32'(LoadFault), 32'(e.fault));
        chk("LoadValid cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      compared++;
      mismatched++;
      $display("FAIL missing LoadValid: got none expected pulse at cycle %0d", sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic f, input int unsigned lat);
    exp_t e;
    e.data = d; e.rd = rd; e.fault = f; e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd,
                      input logic [31:0] exp, input bit split, input string name);
    logic [29:0] w1;
    logic [31:0] d;
    logic        f;
    int unsigned lat;
    w1 = a[31:2] + 30'd1;
    d = exp; f = 1'b0; lat = split ? 3 : 2;
`ifdef SPLIT_LOAD_TRAP_EN
    if (split) begin d = '0; f = 1'b1; lat = 2; end
`endif
    LoadType = t; Addr = a; RdIn = rd; ReqValid = 1'b1;
    @(negedge clk);
    chk({name, " ready T"}, 32'(ReqReady), 32'd1);
    chk({name, " RamEn T"}, 32'(RamEn), 32'd1);
    chk({name, " RamAddr T"}, 32'(RamAddr), 32'(a[31:2]));
    push(d, rd, f, lat);
    @(posedge clk); #1 ReqValid = 1'b0;
    @(negedge clk);
    chk({name, " ready T+1"}, 32'(ReqReady), 32'd0);
    if (split) begin
`ifdef SPLIT_LOAD_TRAP_EN
      chk({name, " RamEn T+1"}, 32'(RamEn), 32'd0);
`else
      chk({name, " RamEn T+1"}, 32'(RamEn), 32'd1);
      chk({name, " RamAddr T+1"}, 32'(RamAddr), 32'(w1));
`endif
    end
    @(posedge clk); #1;
`ifndef SPLIT_LOAD_TRAP_EN
    if (split) begin
      @(negedge clk);
      chk({name, " ready T+2"}, 32'(ReqReady), 32'd0);
      @(posedge clk); #1;
    end
`endif
  endtask

  initial begin
    int unsigned acc;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst ReqReady", 32'(ReqReady), 32'd1);
    chk("rst RamEn", 32'(RamEn), 32'd0);
    chk("rst RamAddr", 32'(RamAddr), 32'd0);
    chk("rst LoadValid", 32'(LoadValid), 32'd0);
    chk("rst LoadData", LoadData, 32'd0);
    chk("rst LoadRd", 32'(LoadRd), 32'd0);
    chk("rst LoadFault", 32'(LoadFault), 32'd0);
    @(posedge clk); #1;

    load(3'b010, 32'h100, 5'd1, 32'h44332211, 1'b0, "LW 100");
    load(3'b000, 32'h103, 5'd2, 32'h00000044, 1'b0, "LB 103");
    load(3'b000, 32'h107, 5'd3, 32'hFFFFFF88, 1'b0, "LB 107");
    load(3'b100, 32'h107, 5'd4, 32'h00000088, 1'b0, "LBU 107");
    load(3'b001, 32'h105, 5'd5, 32'h00007766, 1'b0, "LH 105");
    load(3'b001, 32'h106, 5'd6, 32'hFFFF8877, 1'b0, "LH 106");
    load(3'b101, 32'h106, 5'd7, 32'h00008877, 1'b0, "LHU 106");
    load(3'b001, 32'h103, 5'd8, 32'h00005544, 1'b1, "LH 103");
    load(3'b101, 32'h103, 5'd9, 32'h00005544, 1'b1, "LHU 103");
    load(3'b010, 32'h102, 5'd10, 32'h66554433, 1'b1, "LW 102");
    load(3'b010, 32'h101, 5'd11, 32'h55443322, 1'b1, "LW 101");
    load(3'b011, 32'h100, 5'd12, 32'h44332211, 1'b0, "illegal 011");
    load(3'b111, 32'h103, 5'd13, 32'h77665544, 1'b1, "illegal 111");
    load(3'b010, 32'hFFFFFFFE, 5'd14, 32'h3344DDCC, 1'b1, "LW wrap");

    // clear in IDLE wins over a request
    LoadType = 3'b010; Addr = 32'h100; RdIn = 5'd15; ReqValid = 1'b1; clear = 1'b1;
    @(negedge clk);
    chk("clr idle ready", 32'(ReqReady), 32'd0);
    chk("clr idle RamEn", 32'(RamEn), 32'd0);
    @(posedge clk); #1 ReqValid = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk("clr idle ready after", 32'(ReqReady), 32'd1);
    @(posedge clk); #1;

    // clear in the computing cycle of an aligned load masks the pulse
    LoadType = 3'b010; Addr = 32'h104; RdIn = 5'd16; ReqValid = 1'b1;
    @(posedge clk); #1 ReqValid = 1'b0; clear = 1'b1;
    @(negedge clk);
    chk("clr rd1 RamEn", 32'(RamEn), 32'd0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clr rd1 ready", 32'(ReqReady), 32'd1);
    @(posedge clk); #1;

    // clear while the second word of a split load is in flight
    LoadType = 3'b001; Addr = 32'h103; RdIn = 5'd17; ReqValid = 1'b1;
    @(negedge clk);
`ifdef SPLIT_LOAD_TRAP_EN
    push(32'h0, 5'd17, 1'b1, 2);
`endif
    @(posedge clk); #1 ReqValid = 1'b0;
    @(posedge clk); #1 clear = 1'b1;
    @(negedge clk);
    chk("clr rd2 RamEn", 32'(RamEn), 32'd0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clr rd2 ready", 32'(ReqReady), 32'd1);
    chk("clr rd2 LoadRd held", 32'(LoadRd),
`ifdef SPLIT_LOAD_TRAP_EN
        32'd17);
`else
        32'd14);
`endif
    @(posedge clk); #1;

    // reset during RD1 discards the load and zeroes outputs
    LoadType = 3'b010; Addr = 32'h100; RdIn = 5'd18; ReqValid = 1'b1;
    @(posedge clk); #1 ReqValid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst rd1 LoadValid", 32'(LoadValid), 32'd0);
    chk("rst rd1 LoadData", LoadData, 32'd0);
    chk("rst rd1 LoadRd", 32'(LoadRd), 32'd0);
    chk("rst rd1 RamEn", 32'(RamEn), 32'd0);
    chk("rst rd1 ready", 32'(ReqReady), 32'd1);
    @(posedge clk); #1;

    // ReqValid held: aligned loads accepted every other cycle
    acc = 0;
    LoadType = 3'b010; Addr = 32'h104; RdIn = 5'd19; ReqValid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ReqReady === 1'b1) begin
        acc++;
        push(32'h88776655, 5'd19, 1'b0, 2);
      end
      @(posedge clk); #1;
    end
    ReqValid = 1'b0;
    chk("b2b accepts", acc, 32'd3);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/split_load_unit.md
Name: split_load_unit

Overview:
- Load-side reader for the data memory. The store path writes byte-lane-shifted data into the synchronous DataRam; this block reads it back.
- Accepts one load request at a time (LB/LH/LW/LBU/LHU) and drives the DataRam read port with word addresses.
- A load that crosses a word boundary is split into two back-to-back word reads; the bytes are merged, then sign- or zero-extended.
- Sits between the EX/MEM register outputs and the writeback mux, and stalls the pipeline via ReqReady while a split is in flight.

Parameters:
- ADDR_W, 32, byte address width. Word address is ADDR_W-2 bits.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- clear  in  1  flush: abort any in-flight load
- ReqValid  in  1  load request present
- ReqReady  out  1  request accepted when ReqValid & ReqReady
- LoadType  in  3  RISC-V funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- Addr  in  ADDR_W  byte address
- RdIn  in  5  destination register
- RamEn  out  1  read enable to DataRam port A
- RamAddr  out  ADDR_W-2  word address to DataRam port A
- RamRd  in  32  DataRam read data, valid one cycle after RamAddr
- LoadValid  out  1  one-cycle pulse, result ready
- LoadData  out  32  extended load result
- LoadRd  out  5  destination register of the result
- LoadFault  out  1  misaligned fault (see Optional Feature)

Behaviour:
- Reset: state IDLE; ReqReady=1; RamEn=0; RamAddr=0; LoadValid=0; LoadData=0; LoadRd=0; LoadFault=0. Reset mid-operation discards the load with no LoadValid.
- Illegal LoadType (011, 110, 111) is treated as LW.
- Crossing condition:
  - LH/LHU with Addr[1:0]==3.
  - LW with Addr[1:0]!=0.
  - LB/LBU never cross.
- FSM states: IDLE, RD1, RD2. ReqReady=1 only in IDLE.
- IDLE:
  - On accept at cycle T, RamEn=1 and RamAddr=Addr[ADDR_W-1:2] combinationally in T.
  - Latch LoadType, Addr[1:0], RdIn and a cross flag.
  - Go to RD1.
- RD1 (T+1):
  - If not crossing: compute result from RamRd, register it, LoadValid=1 in T+2, go to IDLE.
  - If crossing: capture RamRd as word0, RamEn=1, RamAddr=word0 address+1, go to RD2.
- RD2 (T+2): merge {RamRd, word0}, register the result, LoadValid=1 in T+3, go to IDLE.
- Word address +1 wraps modulo 2^(ADDR_W-2): 0x3FFFFFFF+1 = 0.
- Merge rule: little-endian. The 64-bit {word1, word0} is shifted right by Addr[1:0]*8 and the low 8/16/32 bits are taken.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- LoadValid is asserted for exactly one cycle. LoadData and LoadRd hold until the next LoadValid.
- A new accept is possible in the cycle after LoadValid's computing cycle returns the FSM to IDLE. Throughput:
  - non-crossing: 1 load per 2 cycles
  - crossing: 1 load per 3 cycles
- clear:
  - In IDLE: clear has priority over ReqValid, so no accept.
  - In RD1/RD2: return to IDLE next cycle, suppress LoadValid, RamEn=0.
- clear and rst_n never corrupt an already-issued LoadValid pulse's data. The pulse itself is masked only if clear is asserted in the computing cycle.

Optional Feature:
- Macro: SPLIT_LOAD_TRAP_EN.
- Defined: crossing loads are not split.
  - RD1 goes straight to IDLE with no second read.
  - In T+2, LoadValid=1, LoadFault=1, LoadData=0.
  - LoadFault pulses with LoadValid only.
- Undefined: split behaviour as above; LoadFault tied 0.

Test Plan:
- Memory: word 0x40 = 0x44332211, word 0x41 = 0x88776655.
- LW 0x100 at T -> RamAddr=0x40 in T; LoadValid at T+2 with LoadData=0x44332211, LoadRd=RdIn.
- LB 0x103 -> 0x00000044. LB 0x107 -> 0xFFFFFF88. LBU 0x107 -> 0x00000088. LH 0x105 -> 0x00007766, no split.
- LH 0x103 at T -> RamAddr 0x40 (T), 0x41 (T+1); ReqReady=0 in T+1..T+2; LoadValid at T+3, LoadData=0x00005544.
- LW 0x102 -> LoadData=0x66554433 at T+3. With SPLIT_LOAD_TRAP_EN: LoadValid+LoadFault at T+2, LoadData=0, RamEn low in T+1.
- LW 0xFFFFFFFE -> RamAddr 0x3FFFFFFF then 0x00000000; merged from the upper halfword of the top word and the lower halfword of word 0.
- clear in RD2 -> no LoadValid, ReqReady=1 next cycle. rst_n=0 in RD1 -> all outputs 0 next cycle, no LoadValid. Back-to-back ReqValid held -> accepts spaced 2 cycles for aligned loads.
